// File: rtl/sipo_frame_receiver.sv
// -----------------------------------------------------------------------------
// sipo_frame_receiver
//
// Serial-in, parallel-out word assembler placed directly downstream of the
// PISO shift register. Bits are sampled on the shift strobe, MSB first, and
// packed into WIDTH-bit words. Each completed word is presented on a
// registered output slot with a valid/ready handshake. A word that completes
// while the slot still holds an unconsumed word is dropped and the sticky
// overrun flag is raised.
//
// Ports
//   clk         in   1      rising-edge clock
//   reset_n     in   1      asynchronous active-low reset, clears all state
//   shift       in   1      bit strobe, serial_in sampled when high
//   serial_in   in   1      serial data, first bit of a word is the MSB
//   clear       in   1      synchronous realign: drop partial word, clear overrun
//   data_out    out  WIDTH  last completed word, stable while data_valid=1
//   data_valid  out  1      data_out holds an unconsumed word
//   data_ready  in   1      consumer accepts when data_valid && data_ready
//   bit_count   out  clog2(WIDTH)  bits collected in the current partial word
//   overrun     out  1      sticky, a completed word was dropped
// -----------------------------------------------------------------------------
module sipo_frame_receiver #(
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     shift,
    input  logic                     serial_in,
    input  logic                     clear,
    output logic [WIDTH-1:0]         data_out,
    output logic                     data_valid,
    input  logic                     data_ready,
    output logic [$clog2(WIDTH)-1:0] bit_count,
    output logic                     overrun
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    // Only the first WIDTH-1 bits of a word need storage: the final bit is
    // taken straight from serial_in on the completing edge.
    logic [WIDTH-2:0] partial_q, partial_d;
    logic [CW-1:0]    bit_count_q, bit_count_d;
    logic [WIDTH-1:0] data_out_q, data_out_d;
    logic             data_valid_q, data_valid_d;
    logic             overrun_q, overrun_d;

    logic             in_last;
    logic             word_done;
    logic             consume;
    logic             slot_free;
    logic [WIDTH-1:0] completed_word;

    always_comb begin
        in_last        = (bit_count_q == LAST_CNT);
        completed_word = {partial_q, serial_in};
        word_done      = shift && !clear && in_last;
        consume        = data_valid_q && data_ready;
        slot_free      = !data_valid_q || consume;

        partial_d    = partial_q;
        bit_count_d  = bit_count_q;
        data_out_d   = data_out_q;
        data_valid_d = data_valid_q;
        overrun_d    = overrun_q;

        // Assembly side: clear has priority over any bit presented this cycle.
        if (clear) begin
            partial_d   = '0;
            bit_count_d = '0;
            overrun_d   = 1'b0;
        end else if (shift) begin
            if (in_last) begin
                partial_d   = '0;
                bit_count_d = '0;
            end else begin
                partial_d   = completed_word[WIDTH-2:0];
                bit_count_d = bit_count_q + CW'(1);
            end
        end

        // Output slot: a consume frees the slot, and a word completing on the
        // same edge refills it, so valid stays high across back-to-back words.
        if (consume) begin
            data_valid_d = 1'b0;
        end
        if (word_done) begin
            if (slot_free) begin
                data_out_d   = completed_word;
                data_valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            partial_q    <= '0;
            bit_count_q  <= '0;
            data_out_q   <= '0;
            data_valid_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            partial_q    <= partial_d;
            bit_count_q  <= bit_count_d;
            data_out_q   <= data_out_d;
            data_valid_q <= data_valid_d;
            overrun_q    <= overrun_d;
        end
    end

    assign data_out   = data_out_q;
    assign data_valid = data_valid_q;
    assign bit_count  = bit_count_q;
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_sipo_frame_receiver.sv
// -----------------------------------------------------------------------------
// tb_sipo_frame_receiver
//
// Self-checking bench for sipo_frame_receiver (WIDTH=8): a table of per-cycle
// vectors with expected outputs, hand-written sequences for gapped shifting and
// asynchronous reset, and a randomized run against a word-level model.
// -----------------------------------------------------------------------------
module tb_sipo_frame_receiver;

    localparam int W  = 8;
    localparam int CW = 3;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          shift;
    logic          serial_in;
    logic          clear;
    logic [W-1:0]  data_out;
    logic          data_valid;
    logic          data_ready;
    logic [CW-1:0] bit_count;
    logic          overrun;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    sipo_frame_receiver #(.WIDTH(W)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .shift      (shift),
        .serial_in  (serial_in),
        .clear      (clear),
        .data_out   (data_out),
        .data_valid (data_valid),
        .data_ready (data_ready),
        .bit_count  (bit_count),
        .overrun    (overrun)
    );

    typedef struct {
        logic         sh;
        logic         b;
        logic         clr;
        logic         rdy;
        logic         ev;
        logic [W-1:0] eo;
        logic [CW-1:0] ec;
        logic         eov;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_all(input logic ev, input logic [W-1:0] eo, input logic [CW-1:0] ec,
                           input logic eov, input string tag);
        chk({tag, ".data_valid"}, 32'(data_valid), 32'(ev));
        chk({tag, ".data_out"},   32'(data_out),   32'(eo));
        chk({tag, ".bit_count"},  32'(bit_count),  32'(ec));
        chk({tag, ".overrun"},    32'(overrun),    32'(eov));
    endtask

    // Drive one cycle of inputs, then sample just after the rising edge.
    task automatic cycle(input logic sh, input logic b, input logic clr, input logic rdy);
        shift = sh; serial_in = b; clear = clr; data_ready = rdy;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0; shift = 1'b0; serial_in = 1'b0; clear = 1'b0; data_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    task automatic push(input logic sh, input logic b, input logic clr, input logic rdy,
                        input logic ev, input logic [W-1:0] eo, input logic [CW-1:0] ec,
                        input logic eov);
        vec_t v;
        v.sh = sh; v.b = b; v.clr = clr; v.rdy = rdy;
        v.ev = ev; v.eo = eo; v.ec = ec; v.eov = eov;
        tbl.push_back(v);
    endtask

    // One word, MSB first; expectations before and on the final bit given separately.
    task automatic push_word(input logic [W-1:0] w, input logic rdy_b, input logic rdy_l,
                             input logic ev_b, input logic [W-1:0] eo_b,
                             input logic ev_l, input logic [W-1:0] eo_l,
                             input logic eov_b, input logic eov_l);
        for (int i = 0; i < W; i++) begin
            if (i < W - 1)
                push(1'b1, w[W-1-i], 1'b0, rdy_b, ev_b, eo_b, CW'(i + 1), eov_b);
            else
                push(1'b1, w[W-1-i], 1'b0, rdy_l, ev_l, eo_l, CW'(0), eov_l);
        end
    endtask

    // Word-level reference: value accumulated arithmetically, one output slot.
    int unsigned m_acc, m_bits, m_out;
    bit          m_valid, m_ovr;

    task automatic model_reset();
        m_acc = 0; m_bits = 0; m_out = 0; m_valid = 0; m_ovr = 0;
    endtask

    task automatic model_step(input logic sh, input logic b, input logic clr, input logic rdy);
        bit taken;
        bit done;
        int unsigned word;
        taken = m_valid && rdy;
        done  = 0;
        word  = 0;
        if (clr) begin
            m_acc = 0; m_bits = 0; m_ovr = 0;
        end else if (sh) begin
            m_acc  = m_acc * 2 + int'(b);
            m_bits = m_bits + 1;
            if (m_bits == W) begin
                done = 1; word = m_acc; m_acc = 0; m_bits = 0;
            end
        end
        if (taken) m_valid = 0;
        if (done) begin
            if (!m_valid) begin
                m_out = word; m_valid = 1;
            end else begin
                m_ovr = 1;
            end
        end
    endtask

    initial begin
        logic [W-1:0] a5;
        logic [W-1:0] c3;
        logic [W-1:0] f0;
        logic [W-1:0] words[3];
        logic [W-1:0] prev;
        int gap;
        logic sh, b, clr, rdy;

        // ---------------- reset state ----------------
        do_reset();
        chk_all(1'b0, 8'h00, 3'd0, 1'b0, "reset");

        // ---------------- gapped 0xA5, ready low ----------------
        a5 = 8'hA5;
        for (int i = 0; i < W; i++) begin
            gap = int'($urandom_range(0, 3));
            for (int g = 0; g < gap; g++) begin
                cycle(1'b0, 1'b1, 1'b0, 1'b0);
                chk("gap.bit_count", 32'(bit_count), 32'(i));
                chk("gap.data_valid", 32'(data_valid), 32'd0);
            end
            cycle(1'b1, a5[W-1-i], 1'b0, 1'b0);
            if (i < W - 1) begin
                chk("a5.data_valid_early", 32'(data_valid), 32'd0);
                chk("a5.bit_count", 32'(bit_count), 32'(i + 1));
            end
        end
        chk_all(1'b1, 8'hA5, 3'd0, 1'b0, "a5_done");

        // ---------------- table-driven vectors ----------------
        do_reset();
        push_word(8'h11, 0, 0, 0, 8'h00, 1, 8'h11, 0, 0);
        push_word(8'h22, 0, 0, 1, 8'h11, 1, 8'h11, 0, 1);      // dropped, overrun
        push(0, 0, 0, 1, 0, 8'h11, 0, 1);                      // consume, out held
        push(0, 0, 1, 0, 0, 8'h11, 0, 0);                      // clear drops overrun
        push_word(8'h11, 0, 0, 0, 8'h11, 1, 8'h11, 0, 0);
        push_word(8'h22, 0, 1, 1, 8'h11, 1, 8'h22, 0, 0);      // consume on final edge
        push(0, 0, 0, 1, 0, 8'h22, 0, 0);
        push(1, 1, 0, 0, 0, 8'h22, 1, 0);
        push(1, 0, 0, 0, 0, 8'h22, 2, 0);
        push(1, 1, 0, 0, 0, 8'h22, 3, 0);
        push(1, 1, 1, 0, 0, 8'h22, 0, 0);                      // clear beats 4th shift
        push_word(8'h5A, 0, 0, 0, 8'h22, 1, 8'h5A, 0, 0);
        words[0] = 8'h3C; words[1] = 8'hFF; words[2] = 8'h01;
        prev = 8'h5A;
        for (int k = 0; k < 3; k++) begin
            push_word(words[k], 1, 1, 0, prev, 1, words[k], 0, 0);
            prev = words[k];
        end
        for (int i = 0; i < tbl.size(); i++) begin
            cycle(tbl[i].sh, tbl[i].b, tbl[i].clr, tbl[i].rdy);
            chk_all(tbl[i].ev, tbl[i].eo, tbl[i].ec, tbl[i].eov, $sformatf("vec%0d", i));
        end

        // ---------------- asynchronous reset mid-word ----------------
        do_reset();
        f0 = 8'hF0;
        for (int i = 0; i < W; i++) cycle(1'b1, f0[W-1-i], 1'b0, 1'b0);
        chk_all(1'b1, 8'hF0, 3'd0, 1'b0, "pre_rst");
        for (int i = 0; i < 5; i++) cycle(1'b1, 1'b1, 1'b0, 1'b0);
        chk("pre_rst.bit_count", 32'(bit_count), 32'd5);
        shift = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        chk_all(1'b0, 8'h00, 3'd0, 1'b0, "async_rst");
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        c3 = 8'hC3;
        for (int i = 0; i < W; i++) cycle(1'b1, c3[W-1-i], 1'b0, 1'b0);
        chk_all(1'b1, 8'hC3, 3'd0, 1'b0, "after_rst");

        // ---------------- randomized run against the model ----------------
        do_reset();
        model_reset();
        for (int n = 0; n < 3000; n++) begin
            sh  = ($urandom_range(0, 9) < 7);
            b   = 1'($urandom);
            clr = ($urandom_range(0, 63) == 0);
            rdy = ($urandom_range(0, 9) < 2);
            cycle(sh, b, clr, rdy);
            model_step(sh, b, clr, rdy);
            chk_all(m_valid, W'(m_out), CW'(m_bits), m_ovr, "rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish, got running expected done");
        $fatal(1);
    end

endmodule
